mem_loader: RTL and testbench

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader.sv | 171 +++++++++++++++++
 tb/tb_mem_loader.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// Streams a byte payload into processor data memory while holding the CPU in
// reset. Optional trailer checksum: define LOADER_CHECKSUM_EN to compile it in.
//
// Ports:
//   clock, reset (sync, active-low)
//   start, length   : begin a load of length bytes (0 = 256)
//   in_data/in_valid/in_ready : byte stream handshake
//   mem_addr/mem_data/mem_wren : data memory write port
//   cpu_hold, busy, done, err  : status
module mem_loader #(
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] length,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_data,
  output logic       mem_wren,
  output logic       cpu_hold,
  output logic       busy,
  output logic       done,
  output logic       err
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd3
  } state_t;
`endif

  state_t     state_q, state_d;
  logic [7:0] count_q, count_d;
  // Holds length-1 so length=0 naturally means 256 bytes.
  logic [7:0] last_q, last_d;

  logic       ready_d;
  logic [7:0] addr_d;
  logic [7:0] data_d;
  logic       wren_d;
  logic       hold_d;
  logic       busy_d;
  logic       done_d;
  logic       accept;

  assign accept = in_valid & in_ready;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       err_q, err_d;
  logic [7:0] trailer_sum;

  assign trailer_sum = sum_q + in_data;
  assign err         = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    last_d  = last_q;
    addr_d  = mem_addr;
    data_d  = mem_data;
    wren_d  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    err_d   = err_q;
`endif

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD;
          last_d  = length - 8'd1;
          count_d = 8'd0;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = 8'd0;
          err_d   = 1'b0;
`endif
        end
      end
      LOAD: begin
        if (accept) begin
          wren_d  = 1'b1;
          addr_d  = BASE_ADDR + count_q;
          data_d  = in_data;
          count_d = count_q + 8'd1;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = sum_q + in_data;
          if (count_q == last_q) state_d = CHECK;
`else
          if (count_q == last_q) state_d = DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        // Trailer byte is consumed but never written to memory.
        if (accept) begin
          err_d   = (trailer_sum != 8'd0);
          state_d = DONE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

`ifdef LOADER_CHECKSUM_EN
    ready_d = (state_d == LOAD) || (state_d == CHECK);
    busy_d  = (state_d == LOAD) || (state_d == CHECK);
    hold_d  = (state_d != DONE) || err_d;
`else
    ready_d = (state_d == LOAD);
    busy_d  = (state_d == LOAD);
    hold_d  = (state_d != DONE);
`endif
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= 8'd0;
      last_q   <= 8'd0;
      in_ready <= 1'b0;
      mem_addr <= 8'd0;
      mem_data <= 8'd0;
      mem_wren <= 1'b0;
      cpu_hold <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      last_q   <= last_d;
      in_ready <= ready_d;
      mem_addr <= addr_d;
      mem_data <= data_d;
      mem_wren <= wren_d;
      cpu_hold <= hold_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      sum_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      err_q <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: two instances (BASE_ADDR 00 and FE)
// share one stimulus stream so address wrap is checked alongside.
module tb_mem_loader;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] length = 8'd0;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;

  logic       a_ready, a_wren, a_hold, a_busy, a_done, a_err;
  logic [7:0] a_addr, a_data;
  logic       b_ready, b_wren, b_hold, b_busy, b_done, b_err;
  logic [7:0] b_addr, b_data;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  mem_loader #(.BASE_ADDR(8'h00)) u_a (
    .clock(clock), .reset(reset), .start(start), .length(length),
    .in_data(in_data), .in_valid(in_valid), .in_ready(a_ready),
    .mem_addr(a_addr), .mem_data(a_data), .mem_wren(a_wren),
    .cpu_hold(a_hold), .busy(a_busy), .done(a_done), .err(a_err)
  );

  mem_loader #(.BASE_ADDR(8'hFE)) u_b (
    .clock(clock), .reset(reset), .start(start), .length(length),
    .in_data(in_data), .in_valid(in_valid), .in_ready(b_ready),
    .mem_addr(b_addr), .mem_data(b_data), .mem_wren(b_wren),
    .cpu_hold(b_hold), .busy(b_busy), .done(b_done), .err(b_err)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Packed status {ready,busy,done,hold,err,wren} for compact compares.
  function automatic logic [5:0] st_a();
    return {a_ready, a_busy, a_done, a_hold, a_err, a_wren};
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b1;
    in_valid = 1'b1;
    tick();
    tick();
    total++;
    if (st_a() !== 6'b000100) begin
      bad++;
      $display("FAIL reset_status got=%b exp=000100", st_a());
    end
    total++;
    if ({a_addr, a_data, b_addr, b_data} !== 32'h0) begin
      bad++;
      $display("FAIL reset_bus got=%h exp=0", {a_addr, a_data, b_addr, b_data});
    end
    start = 1'b0;
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    total++;
    if (st_a() !== 6'b000100) begin
      bad++;
      $display("FAIL idle_hold got=%b exp=000100", st_a());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3] = '{8'h11, 8'h22, 8'h33};
    logic [7:0] b_exp [3] = '{8'hFE, 8'hFF, 8'h00};
    start = 1'b1;
    length = 8'd3;
    tick();
    start = 1'b0;
    total++;
    if (st_a() !== 6'b110100) begin
      bad++;
      $display("FAIL b2b_load got=%b exp=110100", st_a());
    end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = bytes[i];
      tick();
      total++;
      if ({a_wren, a_addr, a_data} !== {1'b1, 8'(i), bytes[i]}) begin
        bad++;
        $display("FAIL b2b_write%0d got=%b/%h/%h exp=1/%h/%h",
                 i, a_wren, a_addr, a_data, 8'(i), bytes[i]);
      end
      total++;
      if (b_addr !== b_exp[i]) begin
        bad++;
        $display("FAIL b2b_wrap%0d got=%h exp=%h", i, b_addr, b_exp[i]);
      end
    end
    in_valid = 1'b0;
    total++;
    if ({a_done, a_hold, a_busy, a_ready} !== 4'b1000) begin
      bad++;
      $display("FAIL b2b_done got=%b exp=1000",
               {a_done, a_hold, a_busy, a_ready});
    end
    tick();
    total++;
    if (a_wren !== 1'b0 || a_done !== 1'b1) begin
      bad++;
      $display("FAIL b2b_after got=%b%b exp=01", a_wren, a_done);
    end
  endtask

  task automatic test_gaps();
    logic       pat [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] b_exp [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    int k = 0;
    start = 1'b1;
    length = 8'd4;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = pat[i];
      in_data = 8'hA0 + 8'(k);
      tick();
      if (pat[i]) begin
        total++;
        if ({b_wren, b_addr, b_data} !== {1'b1, b_exp[k], 8'hA0 + 8'(k)}) begin
          bad++;
          $display("FAIL gap_write%0d got=%b/%h/%h exp=1/%h/%h",
                   k, b_wren, b_addr, b_data, b_exp[k], 8'hA0 + 8'(k));
        end
        k++;
      end else begin
        total++;
        if (b_wren !== 1'b0 || b_busy !== 1'b1) begin
          bad++;
          $display("FAIL gap_stall%0d got=%b%b exp=01", i, b_wren, b_busy);
        end
      end
    end
    total++;
    if (b_done !== 1'b1 || b_hold !== 1'b0) begin
      bad++;
      $display("FAIL gap_done got=%b%b exp=10", b_done, b_hold);
    end
    tick();
    in_valid = 1'b0;
    total++;
    if (b_wren !== 1'b0) begin
      bad++;
      $display("FAIL gap_nowrite_done got=%b exp=0", b_wren);
    end
  endtask

  task automatic test_len256();
    logic [255:0] seen = '0;
    int writes = 0;
    int order_bad = 0;
    start = 1'b1;
    length = 8'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1;
      in_data = 8'(i) ^ 8'h5A;
      tick();
      if (b_wren === 1'b1) begin
        writes++;
        seen[b_addr] = 1'b1;
      end
      if (a_addr !== 8'(i) || a_data !== (8'(i) ^ 8'h5A)) order_bad++;
      if (i == 254) begin
        total++;
        if (a_busy !== 1'b1 || a_done !== 1'b0) begin
          bad++;
          $display("FAIL len256_early got=%b%b exp=10", a_busy, a_done);
        end
      end
    end
    in_valid = 1'b0;
    total++;
    if (order_bad != 0) begin
      bad++;
      $display("FAIL len256_addr got=%0d exp=0 misplaced", order_bad);
    end
    total++;
    if (writes != 256 || seen !== {256{1'b1}}) begin
      bad++;
      $display("FAIL len256_cover got=%0d exp=256 writes", writes);
    end
    total++;
    if (a_done !== 1'b1) begin
      bad++;
      $display("FAIL len256_done got=%b exp=1", a_done);
    end
    tick();
    total++;
    if (a_wren !== 1'b0) begin
      bad++;
      $display("FAIL len256_extra got=%b exp=0", a_wren);
    end
  endtask

  task automatic test_start_ignored();
    start = 1'b1;
    length = 8'd5;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data = 8'hC0 + 8'(i);
      start = (i == 2);
      length = (i == 2) ? 8'd2 : 8'd5;
      tick();
      total++;
      if ({a_wren, a_addr, a_data} !== {1'b1, 8'(i), 8'hC0 + 8'(i)}) begin
        bad++;
        $display("FAIL ign_write%0d got=%b/%h/%h exp=1/%h/%h",
                 i, a_wren, a_addr, a_data, 8'(i), 8'hC0 + 8'(i));
      end
    end
    start = 1'b0;
    in_valid = 1'b0;
    total++;
    if (a_done !== 1'b1) begin
      bad++;
      $display("FAIL ign_done got=%b exp=1", a_done);
    end
  endtask

  task automatic test_reset_midload();
    start = 1'b1;
    length = 8'd5;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data = 8'h70 + 8'(i);
      tick();
    end
    reset = 1'b0;
    start = 1'b1;
    tick();
    total++;
    if (st_a() !== 6'b000100) begin
      bad++;
      $display("FAIL rst_mid got=%b exp=000100", st_a());
    end
    reset = 1'b1;
    start = 1'b0;
    tick();
    total++;
    if (a_wren !== 1'b0 || a_busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_idle got=%b%b exp=00", a_wren, a_busy);
    end
    in_valid = 1'b0;
    start = 1'b1;
    length = 8'd2;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data = 8'h90 + 8'(i);
      tick();
      total++;
      if ({a_wren, a_addr, b_addr} !== {1'b1, 8'(i), 8'hFE + 8'(i)}) begin
        bad++;
        $display("FAIL rst_reload%0d got=%b/%h/%h exp=1/%h/%h",
                 i, a_wren, a_addr, b_addr, 8'(i), 8'hFE + 8'(i));
      end
    end
    in_valid = 1'b0;
    total++;
    if (a_done !== 1'b1) begin
      bad++;
      $display("FAIL rst_reload_done got=%b exp=1", a_done);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] trl [2] = '{8'hFA, 8'hFB};
    logic       e_exp [2] = '{1'b0, 1'b1};
    for (int r = 0; r < 2; r++) begin
      start = 1'b1;
      length = 8'd3;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
        in_valid = 1'b1;
        in_data = 8'(i + 1);
        tick();
      end
      total++;
      if ({a_ready, a_busy, a_done} !== 3'b110) begin
        bad++;
        $display("FAIL ck_check%0d got=%b exp=110", r,
                 {a_ready, a_busy, a_done});
      end
      in_data = trl[r];
      tick();
      in_valid = 1'b0;
      total++;
      if ({a_wren, a_done, a_err, a_hold} !==
          {1'b0, 1'b1, e_exp[r], e_exp[r]}) begin
        bad++;
        $display("FAIL ck_result%0d got=%b exp=01%b%b", r,
                 {a_wren, a_done, a_err, a_hold}, e_exp[r], e_exp[r]);
      end
    end
    start = 1'b1;
    length = 8'd1;
    tick();
    start = 1'b0;
    total++;
    if (a_err !== 1'b0 || a_hold !== 1'b1) begin
      bad++;
      $display("FAIL ck_restart got=%b%b exp=01", a_err, a_hold);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`else
    test_back_to_back();
    test_gaps();
    test_len256();
    test_start_ignored();
    test_reset_midload();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
